local_memory_arbiter: RTL and testbench
=======================================

Name: local_memory_arbiter

Overview:
- Shares one single-port, 1-cycle-latency local SRAM between two requesters.
- Port A is the RV32I core data/instruction memory path; port B is the management/debug path.
- Sequences each access as issue, capture, respond.
- Fixed priority to A, with a starvation guard for B, range checking, and registered response outputs.

Parameters:
- ADDR_BITS, 9, SRAM word-address width (SRAM holds 2**ADDR_BITS 32-bit words).
- MAX_WAIT, 4, number of consecutive A grants allowed while B is pending; 0 disables the guard (A has strict priority).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- a_req  in  1  A access request, held until a_ready
- a_we  in  1  A write (1) / read (0)
- a_byteMask  in  4  A byte lanes (pre-aligned by master)
- a_address  in  32  A byte address
- a_writeData  in  32  A store data
- a_readData  out  32  A load data
- a_ready  out  1  A completion pulse
- a_error  out  1  A out-of-range flag, valid with a_ready
- b_req, b_we, b_byteMask, b_address, b_writeData, b_readData, b_ready, b_error  same as A, for port B
- sram_en  out  1  SRAM access strobe
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  ADDR_BITS  SRAM word address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high.
- Reset:
  - state=IDLE, waitCount=0.
  - All outputs 0: sram_en, sram_we, sram_addr, sram_wdata, *_readData, *_ready, *_error.
  - Reset mid-access drops the access; no ready is issued.
- States: IDLE, ISSUE, CAPTURE. All outputs are registered.
- IDLE:
  - Each master's req is masked during the cycle its own ready is high (treated as consumed).
  - If no unmasked req, stay in IDLE.
  - Otherwise pick an owner, latch its we/byteMask/address/writeData, and go to ISSUE.
  - Choice: A wins if a_req, unless b_req and MAX_WAIT!=0 and waitCount>=MAX_WAIT, in which case B wins.
- ISSUE (1 cycle):
  - In range (address[31:ADDR_BITS+2]==0): sram_en=1, sram_addr=address[ADDR_BITS+1:2], sram_we=we?byteMask:4'b0000, sram_wdata=writeData.
  - Out of range: sram_en=0, sram_we=0.
  - Address bits [1:0] are ignored.
  - Always go to CAPTURE.
- CAPTURE (1 cycle):
  - sram_en, sram_we, sram_addr and sram_wdata return to 0.
  - At the ending edge, load the owner's readData and set its ready=1 for one cycle; set error=1 if out of range.
  - readData = sram_rdata for an in-range read, 0 for writes and out-of-range accesses.
  - Go to IDLE.
- Latency: req high at an IDLE edge → ready high 3 cycles later (in the cycle after CAPTURE).
- Single-master throughput is one access per 4 cycles (re-request is sampled at the edge after the ready cycle).
- Non-owner outputs: readData holds its last value; ready and error stay 0.
- waitCount:
  - Increments (saturating at MAX_WAIT) on each A grant while b_req is high.
  - Clears on B grant.
  - Unchanged otherwise.
- byteMask==0: the access completes normally (sram_en may pulse, sram_we=0); error=0.
- Simultaneous a_req and b_req: only one grant per arbitration; the loser's req must stay held and is granted in a later IDLE.
- Requests arriving while in ISSUE/CAPTURE are not lost; they are evaluated at the next IDLE.

Test Plan:
- A read, addr 0x0000_0010, SRAM word 4 = 0xDEADBEEF → sram_en/sram_addr=4 in ISSUE; a_ready with a_readData=0xDEADBEEF 3 cycles after req; a_error=0.
- B write, addr 0x0000_0008, mask 4'b0011, data 0x12345678 → sram_we=4'b0011, sram_addr=2, sram_wdata=0x12345678 for exactly 1 cycle; b_ready pulse; b_readData=0.
- A and B continuously requesting, MAX_WAIT=4 → grant sequence A,A,A,A,B repeating; waitCount clears on each B grant; MAX_WAIT=0 → B never granted while A requests.
- A read, addr 0x0000_0800 (ADDR_BITS=9) → no sram_en; a_ready=1, a_error=1, a_readData=0.
- rst asserted during ISSUE → all outputs 0 immediately; no ready; after release a held request restarts from IDLE with full 3-cycle latency.
- A holds a_req through the ready cycle, then drops it → exactly one access performed; no duplicate grant.

Source files
------------

// File: rtl/local_memory_arbiter_if.sv
// Bundle of the two requester ports (A: core path, B: management path) and the SRAM port.
// The arbiter takes the slave side; the requesters/SRAM model take the master side.
interface local_memory_arbiter_if #(
   parameter int ADDR_BITS = 9
);
   logic                 a_req;
   logic                 a_we;
   logic [3:0]           a_byteMask;
   logic [31:0]          a_address;
   logic [31:0]          a_writeData;
   logic [31:0]          a_readData;
   logic                 a_ready;
   logic                 a_error;

   logic                 b_req;
   logic                 b_we;
   logic [3:0]           b_byteMask;
   logic [31:0]          b_address;
   logic [31:0]          b_writeData;
   logic [31:0]          b_readData;
   logic                 b_ready;
   logic                 b_error;

   logic                 sram_en;
   logic [3:0]           sram_we;
   logic [ADDR_BITS-1:0] sram_addr;
   logic [31:0]          sram_wdata;
   logic [31:0]          sram_rdata;

   modport slave (
      input  a_req, a_we, a_byteMask, a_address, a_writeData,
      input  b_req, b_we, b_byteMask, b_address, b_writeData,
      input  sram_rdata,
      output a_readData, a_ready, a_error,
      output b_readData, b_ready, b_error,
      output sram_en, sram_we, sram_addr, sram_wdata
   );

   modport master (
      output a_req, a_we, a_byteMask, a_address, a_writeData,
      output b_req, b_we, b_byteMask, b_address, b_writeData,
      output sram_rdata,
      input  a_readData, a_ready, a_error,
      input  b_readData, b_ready, b_error,
      input  sram_en, sram_we, sram_addr, sram_wdata
   );
endinterface

// File: rtl/local_memory_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between requesters A and B.
// A has fixed priority; a wait counter lets a pending B through after MAX_WAIT A grants.
module local_memory_arbiter #(
   parameter int ADDR_BITS = 9,
   parameter int MAX_WAIT  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   local_memory_arbiter_if.slave bus_if
);
   localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;

   state_t               state_q, state_d;
   logic                 owner_b_q, owner_b_d;
   logic                 we_q, we_d;
   logic                 oor_q, oor_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic                 sram_en_q, sram_en_d;
   logic [3:0]           sram_we_q, sram_we_d;
   logic [ADDR_BITS-1:0] sram_addr_q, sram_addr_d;
   logic [31:0]          sram_wdata_q, sram_wdata_d;
   logic                 a_ready_q, a_ready_d, a_error_q, a_error_d;
   logic [31:0]          a_rdata_q, a_rdata_d;
   logic                 b_ready_q, b_ready_d, b_error_q, b_error_d;
   logic [31:0]          b_rdata_q, b_rdata_d;

   logic                 a_pend, b_pend, grant_any, grant_b;
   logic                 sel_we, sel_in_range;
   logic [3:0]           sel_mask;
   logic [31:0]          sel_addr, sel_wdata, sel_word, cap_rdata;

   // A request is treated as consumed during the cycle its own ready is high.
   always_comb begin
      a_pend       = bus_if.a_req & ~a_ready_q;
      b_pend       = bus_if.b_req & ~b_ready_q;
      grant_any    = (state_q == IDLE) && (a_pend || b_pend);
      grant_b      = b_pend && (!a_pend || (MAX_WAIT != 0 && wait_q >= WAIT_MAX));
      sel_we       = grant_b ? bus_if.b_we          : bus_if.a_we;
      sel_mask     = grant_b ? bus_if.b_byteMask    : bus_if.a_byteMask;
      sel_addr     = grant_b ? bus_if.b_address     : bus_if.a_address;
      sel_wdata    = grant_b ? bus_if.b_writeData   : bus_if.a_writeData;
      sel_word     = sel_addr >> 2;
      sel_in_range = (sel_word[31:ADDR_BITS] == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = grant_any ? ISSUE : IDLE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      owner_b_d    = owner_b_q;
      we_d         = we_q;
      oor_d        = oor_q;
      wait_d       = wait_q;
      sram_en_d    = 1'b0;
      sram_we_d    = 4'b0000;
      sram_addr_d  = '0;
      sram_wdata_d = 32'h0;
      a_ready_d    = 1'b0;
      a_error_d    = 1'b0;
      a_rdata_d    = a_rdata_q;
      b_ready_d    = 1'b0;
      b_error_d    = 1'b0;
      b_rdata_d    = b_rdata_q;
      cap_rdata    = (oor_q || we_q) ? 32'h0 : bus_if.sram_rdata;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               owner_b_d = grant_b;
               we_d      = sel_we;
               oor_d     = !sel_in_range;
               if (sel_in_range) begin
                  sram_en_d    = 1'b1;
                  sram_we_d    = sel_we ? sel_mask : 4'b0000;
                  sram_addr_d  = sel_word[ADDR_BITS-1:0];
                  sram_wdata_d = sel_wdata;
               end
               // The starvation count saturates so it never wraps back below MAX_WAIT.
               if (grant_b) begin
                  wait_d = '0;
               end else if (bus_if.b_req && wait_q < WAIT_MAX) begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         CAPTURE: begin
            if (owner_b_q) begin
               b_ready_d = 1'b1;
               b_error_d = oor_q;
               b_rdata_d = cap_rdata;
            end else begin
               a_ready_d = 1'b1;
               a_error_d = oor_q;
               a_rdata_d = cap_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_b_q    <= 1'b0;
         we_q         <= 1'b0;
         oor_q        <= 1'b0;
         wait_q       <= '0;
         sram_en_q    <= 1'b0;
         sram_we_q    <= 4'b0000;
         sram_addr_q  <= '0;
         sram_wdata_q <= 32'h0;
         a_ready_q    <= 1'b0;
         a_error_q    <= 1'b0;
         a_rdata_q    <= 32'h0;
         b_ready_q    <= 1'b0;
         b_error_q    <= 1'b0;
         b_rdata_q    <= 32'h0;
      end else begin
         owner_b_q    <= owner_b_d;
         we_q         <= we_d;
         oor_q        <= oor_d;
         wait_q       <= wait_d;
         sram_en_q    <= sram_en_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         a_ready_q    <= a_ready_d;
         a_error_q    <= a_error_d;
         a_rdata_q    <= a_rdata_d;
         b_ready_q    <= b_ready_d;
         b_error_q    <= b_error_d;
         b_rdata_q    <= b_rdata_d;
      end
   end

   assign bus_if.sram_en    = sram_en_q;
   assign bus_if.sram_we    = sram_we_q;
   assign bus_if.sram_addr  = sram_addr_q;
   assign bus_if.sram_wdata = sram_wdata_q;
   assign bus_if.a_ready    = a_ready_q;
   assign bus_if.a_error    = a_error_q;
   assign bus_if.a_readData = a_rdata_q;
   assign bus_if.b_ready    = b_ready_q;
   assign bus_if.b_error    = b_error_q;
   assign bus_if.b_readData = b_rdata_q;
endmodule

// File: tb/tb_local_memory_arbiter.sv
// Bench for local_memory_arbiter: directed scenarios plus a randomized two-master run
// checked cycle by cycle against a transaction-level reference model.
module tb_local_memory_arbiter;
   localparam int ADDR_BITS = 9;
   localparam int MAX_WAIT  = 4;
   localparam int WORDS     = 1 << ADDR_BITS;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic mem_init = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [31:0] sram_mem [0:WORDS-1];
   logic [31:0] ref_mem  [0:WORDS-1];

   local_memory_arbiter_if #(.ADDR_BITS(ADDR_BITS)) bus ();

   local_memory_arbiter #(.ADDR_BITS(ADDR_BITS), .MAX_WAIT(MAX_WAIT)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // Single-port SRAM model, one-cycle read latency, byte-lane writes.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < WORDS; i++) sram_mem[i] <= init_word(i);
      end else if (bus.sram_en) begin
         bus.sram_rdata <= sram_mem[bus.sram_addr];
         for (int l = 0; l < 4; l++)
            if (bus.sram_we[l]) sram_mem[bus.sram_addr][8*l +: 8] <= bus.sram_wdata[8*l +: 8];
      end
   end

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return 32'h0000_0800 | $urandom;
      return {21'b0, 11'($urandom_range(0, 2047))};
   endfunction

   task automatic test_reset();
      mem_init = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.sram_en !== 1'b0 || bus.sram_we !== 4'h0 || bus.sram_addr !== '0 || bus.sram_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_sram: en=%0b we=%0h addr=%0h wdata=%0h required all 0",
                  bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata);
      end
      n_checks++;
      if (bus.a_ready !== 1'b0 || bus.a_error !== 1'b0 || bus.a_readData !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_a: ready=%0b error=%0b rdata=%0h required all 0",
                  bus.a_ready, bus.a_error, bus.a_readData);
      end
      n_checks++;
      if (bus.b_ready !== 1'b0 || bus.b_error !== 1'b0 || bus.b_readData !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_b: ready=%0b error=%0b rdata=%0h required all 0",
                  bus.b_ready, bus.b_error, bus.b_readData);
      end
      mem_init = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      $display("reset: outputs checked");
   endtask

   task automatic test_a_read();
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_byteMask = 4'hF;
      bus.a_address = 32'h0000_0010; bus.a_writeData = 32'h0;
      @(negedge clk);
      n_checks++;
      if (bus.sram_en !== 1'b1 || bus.sram_addr !== 9'd4 || bus.sram_we !== 4'h0 || bus.a_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL a_read_issue: en=%0b addr=%0h we=%0h ready=%0b required 1/4/0/0",
                  bus.sram_en, bus.sram_addr, bus.sram_we, bus.a_ready);
      end
      @(negedge clk);
      n_checks++;
      if (bus.sram_en !== 1'b0 || bus.a_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL a_read_capture: en=%0b ready=%0b required 0/0", bus.sram_en, bus.a_ready);
      end
      @(negedge clk);
      n_checks++;
      if (bus.a_ready !== 1'b1 || bus.a_readData !== 32'hDEADBEEF || bus.a_error !== 1'b0) begin
         n_fail++;
         $display("FAIL a_read_resp: ready=%0b rdata=%0h error=%0b required 1/deadbeef/0",
                  bus.a_ready, bus.a_readData, bus.a_error);
      end
      bus.a_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.a_ready !== 1'b0 || bus.a_readData !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL a_read_after: ready=%0b rdata=%0h required 0/deadbeef", bus.a_ready, bus.a_readData);
      end
      $display("txn A read addr=00000010 rdata=%08h", bus.a_readData);
   endtask

   task automatic test_b_write();
      logic [31:0] exp_word;
      exp_word = (init_word(2) & 32'hFFFF_0000) | 32'h0000_5678;
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_byteMask = 4'b0011;
      bus.b_address = 32'h0000_0008; bus.b_writeData = 32'h1234_5678;
      @(negedge clk);
      n_checks++;
      if (bus.sram_en !== 1'b1 || bus.sram_we !== 4'b0011 || bus.sram_addr !== 9'd2 || bus.sram_wdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL b_write_issue: en=%0b we=%0h addr=%0h wdata=%0h required 1/3/2/12345678",
                  bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata);
      end
      @(negedge clk);
      n_checks++;
      if (bus.sram_en !== 1'b0 || bus.sram_we !== 4'h0 || bus.sram_addr !== '0 || bus.sram_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL b_write_capture: en=%0b we=%0h addr=%0h wdata=%0h required all 0",
                  bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata);
      end
      @(negedge clk);
      n_checks++;
      if (bus.b_ready !== 1'b1 || bus.b_readData !== 32'h0 || bus.b_error !== 1'b0 || bus.a_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b_write_resp: b_ready=%0b rdata=%0h error=%0b a_ready=%0b required 1/0/0/0",
                  bus.b_ready, bus.b_readData, bus.b_error, bus.a_ready);
      end
      bus.b_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sram_mem[2] !== exp_word || bus.b_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b_write_mem: word2=%0h b_ready=%0b required %0h/0", sram_mem[2], bus.b_ready, exp_word);
      end
      $display("txn B write addr=00000008 mask=3 word=%08h", sram_mem[2]);
   endtask

   task automatic test_out_of_range();
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_byteMask = 4'hF; bus.a_address = 32'h0000_0800;
      @(negedge clk);
      n_checks++;
      if (bus.sram_en !== 1'b0 || bus.sram_we !== 4'h0) begin
         n_fail++;
         $display("FAIL oor_issue: en=%0b we=%0h required 0/0", bus.sram_en, bus.sram_we);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.a_ready !== 1'b1 || bus.a_error !== 1'b1 || bus.a_readData !== 32'h0) begin
         n_fail++;
         $display("FAIL oor_resp: ready=%0b error=%0b rdata=%0h required 1/1/0",
                  bus.a_ready, bus.a_error, bus.a_readData);
      end
      bus.a_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.a_error !== 1'b0 || bus.a_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_after: error=%0b ready=%0b required 0/0", bus.a_error, bus.a_ready);
      end
      $display("txn A read addr=00000800 out of range");
   endtask

   task automatic test_simultaneous();
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_byteMask = 4'hF; bus.a_address = 32'h0000_0014;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_byteMask = 4'hF; bus.b_address = 32'h0000_0018;
      @(negedge clk);
      n_checks++;
      if (bus.sram_en !== 1'b1 || bus.sram_addr !== 9'd5) begin
         n_fail++;
         $display("FAIL simul_first: en=%0b addr=%0h required 1/5", bus.sram_en, bus.sram_addr);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0 || bus.a_readData !== init_word(5)) begin
         n_fail++;
         $display("FAIL simul_a_resp: a_ready=%0b b_ready=%0b rdata=%0h required 1/0/%0h",
                  bus.a_ready, bus.b_ready, bus.a_readData, init_word(5));
      end
      bus.a_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.sram_en !== 1'b1 || bus.sram_addr !== 9'd6) begin
         n_fail++;
         $display("FAIL simul_second: en=%0b addr=%0h required 1/6", bus.sram_en, bus.sram_addr);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0 || bus.b_readData !== init_word(6)) begin
         n_fail++;
         $display("FAIL simul_b_resp: b_ready=%0b a_ready=%0b rdata=%0h required 1/0/%0h",
                  bus.b_ready, bus.a_ready, bus.b_readData, init_word(6));
      end
      bus.b_req = 1'b0;
      @(negedge clk);
      $display("txn A then B reads words 5,6");
   endtask

   task automatic test_hold_through_ready();
      int en_cnt = 0;
      int rdy_cnt = 0;
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_byteMask = 4'hF; bus.a_address = 32'h0000_001C;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (bus.sram_en === 1'b1) en_cnt++;
         if (bus.a_ready === 1'b1) rdy_cnt++;
         if (k == 4) bus.a_req = 1'b0;
      end
      n_checks++;
      if (en_cnt != 1 || rdy_cnt != 1) begin
         n_fail++;
         $display("FAIL hold_single: sram_en cycles=%0d ready pulses=%0d required 1/1", en_cnt, rdy_cnt);
      end
      n_checks++;
      if (bus.a_readData !== init_word(7)) begin
         n_fail++;
         $display("FAIL hold_data: rdata=%0h required %0h", bus.a_readData, init_word(7));
      end
      $display("txn A read addr=0000001c held through ready");
   endtask

   task automatic test_reset_mid_access();
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_byteMask = 4'hF; bus.a_address = 32'h0000_0024;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.sram_en !== 1'b0 || bus.sram_addr !== '0 || bus.a_ready !== 1'b0 ||
          bus.a_readData !== 32'h0 || bus.b_readData !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_clear: en=%0b addr=%0h ready=%0b a_rdata=%0h b_rdata=%0h required all 0",
                  bus.sram_en, bus.sram_addr, bus.a_ready, bus.a_readData, bus.b_readData);
      end
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (bus.a_ready !== 1'b0 || bus.sram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_hold: ready=%0b en=%0b required 0/0", bus.a_ready, bus.sram_en);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.sram_en !== 1'b1 || bus.sram_addr !== 9'd9 || bus.a_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_restart: en=%0b addr=%0h ready=%0b required 1/9/0",
                  bus.sram_en, bus.sram_addr, bus.a_ready);
      end
      @(negedge clk);
      n_checks++;
      if (bus.a_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_early: ready=%0b required 0", bus.a_ready);
      end
      @(negedge clk);
      n_checks++;
      if (bus.a_ready !== 1'b1 || bus.a_readData !== init_word(9) || bus.a_error !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_resp: ready=%0b rdata=%0h error=%0b required 1/%0h/0",
                  bus.a_ready, bus.a_readData, bus.a_error, init_word(9));
      end
      bus.a_req = 1'b0;
      @(negedge clk);
      $display("txn A read addr=00000024 restarted after reset");
   endtask

   task automatic test_random();
      logic        a_act, b_act, ap, bp, t_we;
      logic        pend_b, pend_err;
      logic [31:0] pend_rd, t_addr, t_wd;
      logic [3:0]  t_mask;
      int          phase, m_wait, widx, n_txn;
      logic        e_a_rdy, e_a_err, e_b_rdy, e_b_err, e_en;
      logic [31:0] e_a_rd, e_b_rd, e_wd;
      logic [3:0]  e_we;
      logic [8:0]  e_addr;

      mem_init = 1'b1;
      @(negedge clk);
      mem_init = 1'b0;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
      a_act = 1'b0; b_act = 1'b0; phase = 0; m_wait = 0; n_txn = 0;
      pend_b = 1'b0; pend_err = 1'b0; pend_rd = 32'h0;
      e_a_rdy = 1'b0; e_a_err = 1'b0; e_b_rdy = 1'b0; e_b_err = 1'b0;
      e_en = 1'b0; e_we = 4'h0; e_addr = '0; e_wd = 32'h0;
      e_a_rd = init_word(9); e_b_rd = 32'h0;

      for (int cyc = 0; cyc < 480; cyc++) begin
         // Reference step: what the outputs must be after the coming edge.
         logic        nx_a_rdy, nx_a_err, nx_b_rdy, nx_b_err, nx_en;
         logic [31:0] nx_a_rd, nx_b_rd, nx_wd;
         logic [3:0]  nx_we;
         logic [8:0]  nx_addr;
         nx_a_rdy = 1'b0; nx_a_err = 1'b0; nx_b_rdy = 1'b0; nx_b_err = 1'b0;
         nx_en = 1'b0; nx_we = 4'h0; nx_addr = '0; nx_wd = 32'h0;
         nx_a_rd = e_a_rd; nx_b_rd = e_b_rd;
         if (phase == 0) begin
            ap = bus.a_req && !e_a_rdy;
            bp = bus.b_req && !e_b_rdy;
            if (ap || bp) begin
               pend_b = bp && (!ap || (MAX_WAIT != 0 && m_wait >= MAX_WAIT));
               if (pend_b) m_wait = 0;
               else if (bus.b_req && m_wait < MAX_WAIT) m_wait++;
               t_addr = pend_b ? bus.b_address   : bus.a_address;
               t_we   = pend_b ? bus.b_we        : bus.a_we;
               t_mask = pend_b ? bus.b_byteMask  : bus.a_byteMask;
               t_wd   = pend_b ? bus.b_writeData : bus.a_writeData;
               pend_err = (t_addr >= 32'(4 * WORDS));
               pend_rd  = 32'h0;
               if (!pend_err) begin
                  widx    = int'(t_addr / 4);
                  nx_en   = 1'b1;
                  nx_addr = 9'(widx);
                  nx_we   = t_we ? t_mask : 4'h0;
                  nx_wd   = t_wd;
                  if (t_we) begin
                     for (int l = 0; l < 4; l++)
                        if (t_mask[l]) ref_mem[widx][8*l +: 8] = t_wd[8*l +: 8];
                  end else begin
                     pend_rd = ref_mem[widx];
                  end
               end
               phase = 2;
            end
         end else if (phase == 2) begin
            phase = 1;
         end else begin
            if (pend_b) begin
               nx_b_rdy = 1'b1; nx_b_err = pend_err; nx_b_rd = pend_rd;
            end else begin
               nx_a_rdy = 1'b1; nx_a_err = pend_err; nx_a_rd = pend_rd;
            end
            n_txn++;
            $display("txn %0d port %s err=%0b rdata=%08h", n_txn, pend_b ? "B" : "A", pend_err, pend_rd);
            phase = 0;
         end
         e_a_rdy = nx_a_rdy; e_a_err = nx_a_err; e_a_rd = nx_a_rd;
         e_b_rdy = nx_b_rdy; e_b_err = nx_b_err; e_b_rd = nx_b_rd;
         e_en = nx_en; e_we = nx_we; e_addr = nx_addr; e_wd = nx_wd;

         @(negedge clk);
         n_checks++;
         if (bus.a_ready !== e_a_rdy || bus.a_error !== e_a_err || bus.a_readData !== e_a_rd) begin
            n_fail++;
            $display("FAIL rand_a cyc %0d: ready/error/rdata=%0b/%0b/%0h required %0b/%0b/%0h",
                     cyc, bus.a_ready, bus.a_error, bus.a_readData, e_a_rdy, e_a_err, e_a_rd);
         end
         n_checks++;
         if (bus.b_ready !== e_b_rdy || bus.b_error !== e_b_err || bus.b_readData !== e_b_rd) begin
            n_fail++;
            $display("FAIL rand_b cyc %0d: ready/error/rdata=%0b/%0b/%0h required %0b/%0b/%0h",
                     cyc, bus.b_ready, bus.b_error, bus.b_readData, e_b_rdy, e_b_err, e_b_rd);
         end
         n_checks++;
         if (bus.sram_en !== e_en || bus.sram_we !== e_we ||
             (e_en && (bus.sram_addr !== e_addr || bus.sram_wdata !== e_wd))) begin
            n_fail++;
            $display("FAIL rand_sram cyc %0d: en/we/addr/wdata=%0b/%0h/%0h/%0h required %0b/%0h/%0h/%0h",
                     cyc, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata, e_en, e_we, e_addr, e_wd);
         end

         if (a_act && e_a_rdy) a_act = 1'b0;
         if (!a_act && cyc < 420 && $urandom_range(0, 2) == 0) begin
            a_act = 1'b1;
            bus.a_we = 1'($urandom_range(0, 1)); bus.a_byteMask = 4'($urandom);
            bus.a_address = rand_addr(); bus.a_writeData = $urandom;
         end
         bus.a_req = a_act;
         if (b_act && e_b_rdy) b_act = 1'b0;
         if (!b_act && cyc < 420 && $urandom_range(0, 2) == 0) begin
            b_act = 1'b1;
            bus.b_we = 1'($urandom_range(0, 1)); bus.b_byteMask = 4'($urandom);
            bus.b_address = rand_addr(); bus.b_writeData = $urandom;
         end
         bus.b_req = b_act;
      end
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      $display("random: %0d transactions modelled", n_txn);
   endtask

   initial begin
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_byteMask = 4'h0; bus.a_address = 32'h0; bus.a_writeData = 32'h0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_byteMask = 4'h0; bus.b_address = 32'h0; bus.b_writeData = 32'h0;
      test_reset();
      test_a_read();
      test_b_write();
      test_out_of_range();
      test_simultaneous();
      test_hold_through_ready();
      test_reset_mid_access();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
